// File: rtl/ray_pkg.sv
// ray_pkg: shared types, default widths and popcount helper for the ray dispatch scheduler
package ray_pkg;
  localparam int COORD_W = 32;
  localparam int IDX_W = 26;
  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} sched_state_t;
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] z;
  } ray_dir_t;
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    popcount16 = '0;
    for (int i = 0; i < 16; i++) popcount16 += 5'(v[i]);
  endfunction
endpackage

// File: rtl/ray_dispatch_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or above ptr, wrapping
module rr_arbiter #(
  parameter int NUM_UNITS = 4,
  parameter int PW = 2
) (
  input  logic [NUM_UNITS-1:0] i_req,
  input  logic [PW-1:0]        i_ptr,
  output logic [NUM_UNITS-1:0] o_grant,
  output logic [PW-1:0]        o_grant_idx
);
  logic          w_found;
  logic [PW-1:0] w_idx;
  always_comb begin
    o_grant = '0;
    o_grant_idx = '0;
    w_found = 1'b0;
    w_idx = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      w_idx = PW'((int'(i_ptr) + i) % NUM_UNITS);
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_grant_idx = w_idx;
        w_found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ray_dispatch_scheduler.sv
// ray_dispatch_scheduler: frame FSM and round-robin ray dispatch to intersection units
// RAY_DISPATCH_STATS_EN enables the stall cycle counter; otherwise o_stall_cycles is 0.
module ray_dispatch_scheduler
  import ray_pkg::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int COORD_W = ray_pkg::COORD_W,
  parameter int IDX_W = ray_pkg::IDX_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_start,
  input  logic [12:0]          i_image_width,
  input  logic [12:0]          i_image_height,
  input  logic                 i_gen_valid,
  input  logic [COORD_W-1:0]   i_gen_ray_x,
  input  logic [COORD_W-1:0]   i_gen_ray_y,
  input  logic [COORD_W-1:0]   i_gen_ray_z,
  output logic                 o_gen_ready,
  output logic [NUM_UNITS-1:0] o_unit_valid,
  input  logic [NUM_UNITS-1:0] i_unit_ready,
  output logic [COORD_W-1:0]   o_unit_ray_x,
  output logic [COORD_W-1:0]   o_unit_ray_y,
  output logic [COORD_W-1:0]   o_unit_ray_z,
  output logic [IDX_W-1:0]     o_unit_pixel_idx,
  input  logic [NUM_UNITS-1:0] i_unit_done,
  output logic                 o_busy,
  output logic                 o_frame_done,
  output logic [IDX_W:0]       o_outstanding,
  output logic [31:0]          o_stall_cycles
);
  localparam int PW = $clog2(NUM_UNITS);
  localparam int OW = IDX_W + 1;
  sched_state_t          r_state;
  logic [IDX_W-1:0]      r_total;
  logic [IDX_W-1:0]      r_pix_cnt;
  logic [PW-1:0]         r_rr_ptr;
  logic [OW-1:0]         r_outstanding;
  logic [NUM_UNITS-1:0]  w_grant;
  logic [PW-1:0]         w_grant_idx;
  logic                  w_xfer;
  logic [IDX_W-1:0]      w_total;
  logic [IDX_W-1:0]      w_pix_next;
  logic [OW:0]           w_sum;
  logic [OW:0]           w_dec;
  rr_arbiter #(.NUM_UNITS(NUM_UNITS), .PW(PW)) u_arb (
    .i_req       (i_unit_ready),
    .i_ptr       (r_rr_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );
  assign w_total = IDX_W'({13'b0, i_image_width} * {13'b0, i_image_height});
  assign o_gen_ready = (r_state == DISPATCH) && (|i_unit_ready) && (r_pix_cnt < r_total);
  assign w_xfer = i_gen_valid && o_gen_ready;
  assign o_unit_valid = w_xfer ? w_grant : '0;
  assign o_unit_ray_x = i_gen_ray_x;
  assign o_unit_ray_y = i_gen_ray_y;
  assign o_unit_ray_z = i_gen_ray_z;
  assign o_unit_pixel_idx = r_pix_cnt;
  assign w_pix_next = r_pix_cnt + 1'b1;
  // dispatch and any number of completions are summed; underflow clamps at zero
  assign w_sum = {1'b0, r_outstanding} + (OW+1)'(w_xfer);
  assign w_dec = (OW+1)'(popcount16(16'(i_unit_done)));
  assign o_outstanding = r_outstanding;
  assign o_busy = r_state != IDLE;
  assign o_frame_done = r_state == DONE;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_total <= '0;
      r_pix_cnt <= '0;
      r_rr_ptr <= '0;
      r_outstanding <= '0;
    end else begin
      r_outstanding <= (w_sum >= w_dec) ? OW'(w_sum - w_dec) : '0;
      case (r_state)
        IDLE: if (i_start) begin
          r_total <= w_total;
          r_pix_cnt <= '0;
          r_state <= (w_total != '0) ? DISPATCH : DONE;
        end
        DISPATCH: if (w_xfer) begin
          r_pix_cnt <= w_pix_next;
          r_rr_ptr <= (w_grant_idx == PW'(NUM_UNITS-1)) ? '0 : w_grant_idx + 1'b1;
          if (w_pix_next == r_total) r_state <= DRAIN;
        end
        DRAIN: if (r_outstanding == '0) r_state <= DONE;
        default: r_state <= IDLE;
      endcase
    end
  end
  a_done_underflow: assert property (@(posedge clk) disable iff (!reset_n) w_dec <= w_sum);
`ifdef RAY_DISPATCH_STATS_EN
  logic [31:0] r_stall_cycles;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_stall_cycles <= '0;
    else if (r_state == IDLE && i_start) r_stall_cycles <= '0;
    else if (r_state == DISPATCH && i_gen_valid && !(|i_unit_ready) && r_stall_cycles != '1)
      r_stall_cycles <= r_stall_cycles + 1'b1;
  end
  assign o_stall_cycles = r_stall_cycles;
`else
  assign o_stall_cycles = '0;
`endif
endmodule

// File: tb/tb_ray_dispatch_scheduler.sv
// tb_ray_dispatch_scheduler: vector table plus scoreboard checks of the ray dispatch scheduler
module tb_ray_dispatch_scheduler;
  localparam int N = 4;
  localparam int CW = 32;
  localparam int IW = 26;
`ifdef RAY_DISPATCH_STATS_EN
  localparam int EXP_STALL = 10;
`else
  localparam int EXP_STALL = 0;
`endif
  logic clk = 1'b0;
  logic reset_n;
  logic st;
  logic [12:0] w, h;
  logic gv;
  logic [CW-1:0] rx, ry, rz;
  logic [N-1:0] rdy, dn;
  logic o_gen_ready, o_busy, o_frame_done;
  logic [N-1:0] o_unit_valid;
  logic [CW-1:0] o_unit_ray_x, o_unit_ray_y, o_unit_ray_z;
  logic [IW-1:0] o_unit_pixel_idx;
  logic [IW:0] o_outstanding;
  logic [31:0] o_stall_cycles;
  int total_c = 0;
  int pass_c = 0;
  typedef struct {
    logic st; logic [12:0] w; logic [12:0] h;
    logic [3:0] rdy; logic gv; logic [3:0] dn;
    logic gr; logic [3:0] uv; int idx; int out; logic busy; logic fd;
  } vec_t;
  typedef struct { logic [3:0] uv; int idx; } sb_t;
  sb_t sb[$];
  vec_t vt[$];

  always #5 clk = ~clk;

  ray_dispatch_scheduler #(.NUM_UNITS(N), .COORD_W(CW), .IDX_W(IW)) dut (
    .clk(clk), .reset_n(reset_n), .i_start(st), .i_image_width(w), .i_image_height(h),
    .i_gen_valid(gv), .i_gen_ray_x(rx), .i_gen_ray_y(ry), .i_gen_ray_z(rz),
    .o_gen_ready(o_gen_ready), .o_unit_valid(o_unit_valid), .i_unit_ready(rdy),
    .o_unit_ray_x(o_unit_ray_x), .o_unit_ray_y(o_unit_ray_y), .o_unit_ray_z(o_unit_ray_z),
    .o_unit_pixel_idx(o_unit_pixel_idx), .i_unit_done(dn), .o_busy(o_busy),
    .o_frame_done(o_frame_done), .o_outstanding(o_outstanding), .o_stall_cycles(o_stall_cycles)
  );

  function automatic vec_t mk(input logic s, input int ww, input int hh, input logic [3:0] r,
                              input logic g, input logic [3:0] d, input logic gr, input logic [3:0] uv,
                              input int idx, input int out, input logic busy, input logic fd);
    vec_t v;
    v.st = s; v.w = 13'(ww); v.h = 13'(hh); v.rdy = r; v.gv = g; v.dn = d;
    v.gr = gr; v.uv = uv; v.idx = idx; v.out = out; v.busy = busy; v.fd = fd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_c++;
    if (act === exp) pass_c++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic sb_check();
    sb_t e;
    if (o_unit_valid != '0) begin
      if (sb.size() == 0) chk("sb_unexpected", 32'(o_unit_valid), 32'(0));
      else begin
        e = sb.pop_front();
        chk("sb_grant", 32'(o_unit_valid), 32'(e.uv));
        chk("sb_idx", 32'(o_unit_pixel_idx), e.idx);
        chk("ray_x", o_unit_ray_x, rx);
        chk("ray_z", o_unit_ray_z, rz);
      end
    end else if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("sb_missing", 32'(o_unit_valid), 32'(e.uv));
    end
  endtask

  task automatic drive(input logic s, input int ww, input int hh, input logic [3:0] r,
                       input logic g, input logic [3:0] d, input logic [3:0] exp_uv, input int exp_idx);
    @(posedge clk);
    #1;
    st = s; w = 13'(ww); h = 13'(hh); rdy = r; gv = g; dn = d;
    rx = $urandom; ry = $urandom; rz = $urandom;
    if (exp_uv != '0) sb.push_back('{exp_uv, exp_idx});
    @(negedge clk);
    sb_check();
  endtask

  initial begin
    // 2x2 frame, all ready, all done in one cycle
    vt.push_back(mk(1, 2, 2, 4'h0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 4'hF, 1, 4'h0, 1, 4'h1, 0, 0, 1, 0));
    vt.push_back(mk(0, 0, 0, 4'hF, 1, 4'h0, 1, 4'h2, 1, 1, 1, 0));
    vt.push_back(mk(0, 0, 0, 4'hF, 1, 4'h0, 1, 4'h4, 2, 2, 1, 0));
    vt.push_back(mk(0, 0, 0, 4'hF, 1, 4'h0, 1, 4'h8, 3, 3, 1, 0));
    vt.push_back(mk(0, 0, 0, 4'hF, 1, 4'h0, 0, 4'h0, 0, 4, 1, 0));
    vt.push_back(mk(0, 0, 0, 4'h0, 0, 4'hF, 0, 4'h0, 0, 4, 1, 0));
    vt.push_back(mk(0, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 0, 1, 0));
    vt.push_back(mk(0, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 0, 1, 1));
    vt.push_back(mk(0, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0));
    // 3x1 frame, unit 1 busy
    vt.push_back(mk(1, 3, 1, 4'h0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 4'hD, 1, 4'h0, 1, 4'h1, 0, 0, 1, 0));
    vt.push_back(mk(0, 0, 0, 4'hD, 1, 4'h0, 1, 4'h4, 1, 1, 1, 0));
    vt.push_back(mk(0, 0, 0, 4'hD, 1, 4'h0, 1, 4'h8, 2, 2, 1, 0));
    vt.push_back(mk(0, 0, 0, 4'hD, 1, 4'hD, 0, 4'h0, 0, 3, 1, 0));
    vt.push_back(mk(0, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 0, 1, 0));
    vt.push_back(mk(0, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 0, 1, 1));
    vt.push_back(mk(0, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0));
    // dispatch together with two completions
    vt.push_back(mk(1, 2, 2, 4'h0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 4'hF, 1, 4'h0, 1, 4'h1, 0, 0, 1, 0));
    vt.push_back(mk(0, 0, 0, 4'hF, 1, 4'h0, 1, 4'h2, 1, 1, 1, 0));
    vt.push_back(mk(0, 0, 0, 4'hF, 1, 4'h0, 1, 4'h4, 2, 2, 1, 0));
    vt.push_back(mk(0, 0, 0, 4'hF, 1, 4'h3, 1, 4'h8, 3, 3, 1, 0));
    vt.push_back(mk(0, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 2, 1, 0));
    vt.push_back(mk(0, 0, 0, 4'h0, 0, 4'hC, 0, 4'h0, 0, 2, 1, 0));
    vt.push_back(mk(0, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 0, 1, 0));
    vt.push_back(mk(0, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 0, 1, 1));
    vt.push_back(mk(0, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0));

    reset_n = 1'b0; st = 1'b0; w = '0; h = '0; gv = 1'b1; rdy = 4'hF; dn = '0;
    rx = '0; ry = '0; rz = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_gen_ready", 32'(o_gen_ready), 0);
    chk("rst_unit_valid", 32'(o_unit_valid), 0);
    chk("rst_frame_done", 32'(o_frame_done), 0);
    chk("rst_outstanding", 32'(o_outstanding), 0);
    chk("rst_stall", o_stall_cycles, 0);
    reset_n = 1'b1; gv = 1'b0; rdy = '0;

    foreach (vt[i]) begin
      drive(vt[i].st, int'(vt[i].w), int'(vt[i].h), vt[i].rdy, vt[i].gv, vt[i].dn, vt[i].uv, vt[i].idx);
      chk("gen_ready", 32'(o_gen_ready), 32'(vt[i].gr));
      chk("busy", 32'(o_busy), 32'(vt[i].busy));
      chk("frame_done", 32'(o_frame_done), 32'(vt[i].fd));
      chk("outstanding", 32'(o_outstanding), vt[i].out);
    end

    // zero-size frame
    drive(1, 0, 5, 4'h0, 0, 4'h0, 4'h0, 0);
    chk("zero_busy0", 32'(o_busy), 0);
    drive(0, 0, 0, 4'hF, 1, 4'h0, 4'h0, 0);
    chk("zero_fd", 32'(o_frame_done), 1);
    chk("zero_gen_ready", 32'(o_gen_ready), 0);
    drive(0, 0, 0, 4'hF, 1, 4'h0, 4'h0, 0);
    chk("zero_idle", 32'(o_busy), 0);

    // no ready unit, then start during drain
    drive(1, 1, 1, 4'h0, 0, 4'h0, 4'h0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 4'h0, 1, 4'h0, 4'h0, 0);
      chk("stall_gen_ready", 32'(o_gen_ready), 0);
    end
    drive(0, 0, 0, 4'hF, 1, 4'h0, 4'h1, 0);
    chk("stall_count", o_stall_cycles, EXP_STALL);
    drive(1, 2, 2, 4'h0, 1, 4'h0, 4'h0, 0);
    chk("drain_busy", 32'(o_busy), 1);
    chk("drain_out", 32'(o_outstanding), 1);
    drive(0, 0, 0, 4'hF, 1, 4'h1, 4'h0, 0);
    chk("drain_start_ignored", 32'(o_gen_ready), 0);
    drive(0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 0);
    chk("drain_fd_early", 32'(o_frame_done), 0);
    drive(0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 0);
    chk("drain_fd", 32'(o_frame_done), 1);
    drive(0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 0);
    chk("drain_idle", 32'(o_busy), 0);
    chk("stall_hold", o_stall_cycles, EXP_STALL);

    // reset mid-frame after three transfers
    drive(1, 2, 2, 4'h0, 0, 4'h0, 4'h0, 0);
    drive(0, 0, 0, 4'hF, 1, 4'h0, 4'h2, 0);
    drive(0, 0, 0, 4'hF, 1, 4'h0, 4'h4, 1);
    drive(0, 0, 0, 4'hF, 1, 4'h0, 4'h8, 2);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(o_busy), 0);
    chk("mid_rst_gen_ready", 32'(o_gen_ready), 0);
    chk("mid_rst_unit_valid", 32'(o_unit_valid), 0);
    chk("mid_rst_out", 32'(o_outstanding), 0);
    chk("mid_rst_idx", 32'(o_unit_pixel_idx), 0);
    chk("mid_rst_stall", o_stall_cycles, 0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 0);
    drive(1, 2, 2, 4'h0, 0, 4'h0, 4'h0, 0);
    drive(0, 0, 0, 4'hF, 1, 4'h0, 4'h1, 0);
    chk("restart_busy", 32'(o_busy), 1);
    drive(0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 0);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", pass_c, total_c);
    $finish;
  end
endmodule
